// File: rtl/afu_base_pkg.sv
// Shared AFU definitions: scheduler FSM state and the two-way round-robin pick.
package afu_base;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

  // One-hot pick between two requesters; rr_ptr names the favoured one on a tie.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic rr_ptr);
    logic [1:0] pick;
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = rr_ptr ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/request_scheduler_arbiter.sv
// Two-requester round-robin arbiter with a zero-latency grant and a registered priority pointer.
module rr_arbiter_2
  import afu_base::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic rr_ptr_reg;
  logic rr_ptr_next;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      grant = rr_pick(req, rr_ptr_reg);
    end
  end

  // Priority passes to the other requester after any grant; it holds otherwise.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant[0]) begin
      rr_ptr_next = 1'b1;
    end else if (grant[1]) begin
      rr_ptr_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= 1'b0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

endmodule

// File: rtl/request_scheduler.sv
// Channel-0 read request scheduler: arbitrates two requesters, tracks in-flight reads
// against a credit limit, and supports a drain/quiesce handshake.
module request_scheduler
  import afu_base::*;
#(
  parameter int MAX_OUTSTANDING = 64,
  parameter int COUNT_WIDTH     = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_grant,
  input  logic                   tx_almost_full,
  input  logic                   resp_valid,
  input  logic                   drain,
  output logic [COUNT_WIDTH-1:0] outstanding,
  output logic                   drained,
  output logic                   underflow_err
);

  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_OUTSTANDING);

  sched_state_t           state_reg;
  logic [COUNT_WIDTH-1:0] outstanding_reg;
  logic [COUNT_WIDTH-1:0] outstanding_next;
  logic                   drained_reg;
  logic                   underflow_err_reg;
  logic                   underflow_hit;
  logic                   can_issue;
  logic                   arb_enable;
  logic                   granted;

  // The limit compares against the registered count, so a same-cycle response
  // at the limit frees a slot only from the next cycle on.
  assign can_issue  = (state_reg == RUN) && !tx_almost_full && (outstanding_reg < MAX_COUNT);
  assign arb_enable = can_issue && !reset;

  rr_arbiter_2 u_arbiter (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .enable (arb_enable),
    .grant  (req_grant)
  );

  assign granted = |req_grant;

  always_comb begin
    outstanding_next = outstanding_reg;
    underflow_hit    = 1'b0;
    if (granted && !resp_valid) begin
      outstanding_next = outstanding_reg + COUNT_WIDTH'(1);
    end else if (resp_valid && !granted) begin
      if (outstanding_reg == '0) begin
        underflow_hit = 1'b1;
      end else begin
        outstanding_next = outstanding_reg - COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= RUN;
      outstanding_reg   <= '0;
      drained_reg       <= 1'b0;
      underflow_err_reg <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_next;
      if (underflow_hit) begin
        underflow_err_reg <= 1'b1;
      end
      case (state_reg)
        RUN: begin
          drained_reg <= 1'b0;
          if (drain) begin
            state_reg <= DRAIN;
          end
        end
        // Drain deassertion is ignored here; only an empty pipeline ends the drain.
        DRAIN: begin
          if (outstanding_reg == '0) begin
            state_reg   <= DONE;
            drained_reg <= 1'b1;
          end
        end
        DONE: begin
          if (!drain) begin
            state_reg   <= RUN;
            drained_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= RUN;
          drained_reg <= 1'b0;
        end
      endcase
    end
  end

  assign outstanding   = outstanding_reg;
  assign drained       = drained_reg;
  assign underflow_err = underflow_err_reg;

endmodule

// File: tb/tb_request_scheduler.sv
// Bench for request_scheduler: directed vector table, then randomized traffic against a reference model.
module tb_request_scheduler;

  localparam int MAXO = 4;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_grant;
  logic          tx_almost_full;
  logic          resp_valid;
  logic          drain;
  logic [CW-1:0] outstanding;
  logic          drained;
  logic          underflow_err;

  request_scheduler #(.MAX_OUTSTANDING(MAXO), .COUNT_WIDTH(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_grant      (req_grant),
    .tx_almost_full (tx_almost_full),
    .resp_valid     (resp_valid),
    .drain          (drain),
    .outstanding    (outstanding),
    .drained        (drained),
    .underflow_err  (underflow_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: abstract mode name, priority owner, in-flight tally, sticky error.
  string m_mode = "RUN";
  int    m_prio = 0;
  int    m_cnt  = 0;
  bit    m_err  = 0;

  int s_grant, s_out, s_drained, s_err;

  typedef struct {
    bit [1:0] rv;
    bit       taf;
    bit       rsp;
    bit       drn;
    bit       rst;
    int       grant;
    int       outs;
    int       drnd;
    int       err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_grant(input bit [1:0] rv, input bit taf, input bit rst);
    if (rst || m_mode != "RUN" || taf || m_cnt >= MAXO || rv == 2'b00) return 0;
    if (rv == 2'b11) return (m_prio == 0) ? 1 : 2;
    return int'(rv);
  endfunction

  task automatic model_step(input bit [1:0] rv, input bit taf, input bit rsp, input bit drn, input bit rst);
    int g;
    int old_cnt;
    g = model_grant(rv, taf, rst);
    if (rst) begin
      m_mode = "RUN"; m_prio = 0; m_cnt = 0; m_err = 0;
      return;
    end
    old_cnt = m_cnt;
    if (g == 1) m_prio = 1;
    if (g == 2) m_prio = 0;
    if (g != 0 && !rsp) m_cnt = m_cnt + 1;
    else if (rsp && g == 0) begin
      if (m_cnt == 0) m_err = 1;
      else m_cnt = m_cnt - 1;
    end
    if (m_mode == "RUN") begin
      if (drn) m_mode = "DRAIN";
    end else if (m_mode == "DRAIN") begin
      if (old_cnt == 0) m_mode = "DONE";
    end else if (!drn) begin
      m_mode = "RUN";
    end
  endtask

  // Drive inputs just after the edge, sample mid-cycle, then advance the model and the clock.
  task automatic cyc(input bit [1:0] rv, input bit taf, input bit rsp, input bit drn, input bit rst);
    req_valid = rv; tx_almost_full = taf; resp_valid = rsp; drain = drn; reset = rst;
    #4;
    s_grant = int'(req_grant); s_out = int'(outstanding);
    s_drained = int'(drained); s_err = int'(underflow_err);
    model_step(rv, taf, rsp, drn, rst);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input bit [1:0] rv, input bit taf, input bit rsp, input bit drn,
                              input bit rst, input int g, input int o, input int d, input int e);
    vec_t v;
    v.rv = rv; v.taf = taf; v.rsp = rsp; v.drn = drn; v.rst = rst;
    v.grant = g; v.outs = o; v.drnd = d; v.err = e;
    return v;
  endfunction

  initial begin
    bit [1:0] rv;
    bit taf, rsp, drn, rst;
    int eg;
    //               rv    taf rsp drn rst  grant out drained err
    vecs.push_back(mk(2'b11, 0, 0, 0, 1,   0, 0, 0, 0)); // grant blocked in reset
    vecs.push_back(mk(2'b11, 0, 0, 0, 0,   1, 0, 0, 0)); // alternate 01,10,01,10
    vecs.push_back(mk(2'b11, 0, 0, 0, 0,   2, 1, 0, 0));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0,   1, 2, 0, 0));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0,   2, 3, 0, 0));
    vecs.push_back(mk(2'b01, 0, 0, 0, 0,   0, 4, 0, 0)); // full: no grant
    vecs.push_back(mk(2'b01, 0, 1, 0, 0,   0, 4, 0, 0)); // response at limit does not enable grant
    vecs.push_back(mk(2'b01, 0, 1, 0, 0,   1, 3, 0, 0)); // grant + response: count holds
    vecs.push_back(mk(2'b00, 0, 0, 0, 0,   0, 3, 0, 0));
    vecs.push_back(mk(2'b11, 1, 0, 0, 0,   0, 3, 0, 0)); // backpressure
    vecs.push_back(mk(2'b11, 0, 0, 0, 0,   2, 3, 0, 0)); // priority kept across backpressure
    vecs.push_back(mk(2'b00, 0, 0, 0, 0,   0, 4, 0, 0));
    vecs.push_back(mk(2'b00, 0, 1, 0, 0,   0, 4, 0, 0));
    vecs.push_back(mk(2'b11, 0, 1, 1, 0,   1, 3, 0, 0)); // drain pulse, still RUN this cycle
    vecs.push_back(mk(2'b11, 0, 1, 0, 0,   0, 3, 0, 0)); // DRAIN: no grants
    vecs.push_back(mk(2'b11, 0, 1, 0, 0,   0, 2, 0, 0));
    vecs.push_back(mk(2'b11, 0, 1, 0, 0,   0, 1, 0, 0));
    vecs.push_back(mk(2'b11, 0, 0, 1, 0,   0, 0, 0, 0)); // count hit 0; DONE next edge
    vecs.push_back(mk(2'b11, 0, 0, 1, 0,   0, 0, 1, 0)); // DONE holds with drain high
    vecs.push_back(mk(2'b11, 0, 0, 0, 0,   0, 0, 1, 0));
    vecs.push_back(mk(2'b11, 0, 0, 0, 0,   2, 0, 0, 0)); // back in RUN, grants resume
    vecs.push_back(mk(2'b00, 0, 1, 0, 0,   0, 1, 0, 0));
    vecs.push_back(mk(2'b00, 0, 1, 0, 0,   0, 0, 0, 0)); // underflow
    vecs.push_back(mk(2'b00, 0, 0, 0, 0,   0, 0, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0,   0, 0, 0, 1)); // sticky
    vecs.push_back(mk(2'b11, 0, 0, 0, 1,   0, 0, 0, 1)); // reset cycle
    vecs.push_back(mk(2'b01, 0, 0, 0, 0,   1, 0, 0, 0)); // cleared, rr_ptr back to 0

    req_valid = 2'b00; tx_almost_full = 1'b0; resp_valid = 1'b0; drain = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(2'b00, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      cyc(vecs[i].rv, vecs[i].taf, vecs[i].rsp, vecs[i].drn, vecs[i].rst);
      $display("vec %0d: rv=%b rst=%0d grant=%0d out=%0d drained=%0d err=%0d",
               i, vecs[i].rv, vecs[i].rst, s_grant, s_out, s_drained, s_err);
      check($sformatf("vec%0d grant", i), s_grant, vecs[i].grant);
      check($sformatf("vec%0d outstanding", i), s_out, vecs[i].outs);
      check($sformatf("vec%0d drained", i), s_drained, vecs[i].drnd);
      check($sformatf("vec%0d underflow_err", i), s_err, vecs[i].err);
    end

    // Randomized traffic; drain is held in bursts so the DRAIN/DONE path is exercised.
    drn = 0;
    for (int n = 0; n < 600; n++) begin
      rv  = 2'($urandom_range(0, 3));
      taf = ($urandom_range(0, 3) == 0);
      rsp = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 19) == 0) drn = !drn;
      eg = model_grant(rv, taf, rst);
      begin
        int eo, ed, ee;
        eo = m_cnt; ed = (m_mode == "DONE") ? 1 : 0; ee = int'(m_err);
        cyc(rv, taf, rsp, drn, rst);
        $display("rnd %0d: rv=%b taf=%0d rsp=%0d drn=%0d rst=%0d grant=%0d out=%0d drained=%0d err=%0d",
                 n, rv, taf, rsp, drn, rst, s_grant, s_out, s_drained, s_err);
        check($sformatf("rnd%0d grant", n), s_grant, eg);
        check($sformatf("rnd%0d outstanding", n), s_out, eo);
        check($sformatf("rnd%0d drained", n), s_drained, ed);
        check($sformatf("rnd%0d underflow_err", n), s_err, ee);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
